bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

Sequential converter that takes a packed multi-digit BCD word, such as the 8-bit two-digit result of the team's BCD adder, and returns its plain unsigned binary value. It runs one decimal digit per clock, most-significant digit first, as a multiply-by-ten-and-add accumulator. A start/busy/done handshake lets it sit between the BCD arithmetic datapath and binary consumers such as comparators and the display driver.

## Interface
- DIGITS, default 2: number of BCD digits in the input word.
- BIN_W, default 7: binary output width; must satisfy 2^BIN_W >= 10^DIGITS (7 for 2 digits, 10 for 3).
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  reset, asynchronous, active-low; clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD operand; digit 0 is in [3:0], the MSD in the top nibble.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin_out/err are updated.
- bin_out  output  BIN_W  converted value; held until the next done.
- err  output  1  invalid-digit flag for the last conversion; held with bin_out.

## Operation
- States: IDLE, CONV. Reset state is IDLE.
- IDLE, start=1:
  - Capture bcd_in into the shift register.
  - Clear the accumulator and the digit counter (cnt=0).
  - Go to CONV.
- IDLE, start=0: no change.
- CONV, each edge:
  - acc <= (acc<<3) + (acc<<1) + top_nibble, truncated to BIN_W bits.
  - Shift the register left by 4.
  - cnt <= cnt+1.
- CONV, on the edge where cnt = DIGITS-1:
  - Load the final acc into bin_out and load err.
  - Pulse done; return to IDLE.
- start while in CONV is ignored; the operand captured at start is used, and later changes to bcd_in have no effect.
- Arithmetic: the accumulator is BIN_W wide and is computed modulo 2^BIN_W. For valid input and a legal BIN_W no truncation ever occurs.
- Invalid digit (nibble > 9): the nibble value is accumulated literally, e.g. 0xA counts as 10.
- Reset values: busy=0, done=0, bin_out=0, err=0, state IDLE, acc=0, cnt=0.
- Reset mid-conversion: the conversion is aborted with no done pulse, and bin_out/err return to 0.

## Timing
- Latency: start sampled at edge k. busy=1 after edge k. done=1 for exactly the cycle after edge k+DIGITS; busy=0 after that same edge.
- Throughput: one conversion per DIGITS+1 cycles with start held high. Start is accepted in the cycle done is high, because the FSM is already in IDLE.
- busy and done are never high in the same cycle.
- bin_out and err change only on the edge that raises done, or on reset.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- BCD2BIN_CHECK_EN defined:
  - Each digit is compared with 9 as it is consumed, and a sticky flag is ORed across the conversion.
  - err reflects that flag at done.
- BCD2BIN_CHECK_EN undefined:
  - No digit checking logic; err is tied to 0.
  - Conversion data path and timing are unchanged.

## Test plan
- DIGITS=2, BIN_W=7, bcd_in=0x99, start pulse → busy for 2 cycles, then done with bin_out=99 (0x63), err=0.
- bcd_in=0x00, then 0x10, then 0x09, each as a separate request → bin_out=0, 10, 9 in turn; each done exactly 2 cycles after its start edge.
- BCD2BIN_CHECK_EN defined, bcd_in=0x4A → done with bin_out=50, err=1. Same stimulus with the macro undefined → bin_out=50, err=0.
- Start 0x25, then drive start=1 with bcd_in=0x77 while busy → result 25; the request during busy is not accepted.
- Start 0x25 with start held high, then bcd_in=0x31 presented in the done cycle → result 25 then 31, back-to-back, 3 cycles apart.
- reset_n low for part of a cycle after the first CONV edge of 0x87 → busy, done, bin_out, err all 0 immediately; no done pulse follows.
- DIGITS=3, BIN_W=10, bcd_in=0x999 → done after 3 cycles with bin_out=999.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// ----------------------------------------------------------------------------
// bcd_to_bin_if
// Handshake/data bundle for the sequential BCD-to-binary converter.
//   start   : conversion request (driven by master)
//   bcd_in  : packed BCD operand, digit 0 in [3:0], MSD in the top nibble
//   busy    : conversion in progress (driven by converter)
//   done    : one-cycle pulse when bin_out/err are updated
//   bin_out : converted binary value, held until the next done
//   err     : invalid-digit flag for the last conversion
// Modports: master (requester side), slave (converter side).
// ----------------------------------------------------------------------------
interface bcd_to_bin_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// ----------------------------------------------------------------------------
// bcd_to_bin
// Sequential packed-BCD to unsigned binary converter. Consumes one decimal
// digit per clock, most-significant first, with a multiply-by-ten-and-add
// accumulator (acc*10 = (acc<<3) + (acc<<1)), modulo 2^BIN_W.
//
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, clears all state
//   bus     : bcd_to_bin_if.slave (start, bcd_in -> busy, done, bin_out, err)
//
// Parameters:
//   DIGITS : number of BCD digits in bcd_in
//   BIN_W  : binary width, 2^BIN_W >= 10^DIGITS for lossless conversion
//
// Build option:
//   BCD2BIN_CHECK_EN : when defined, digits > 9 set a sticky error flag that
//                      is reported on err at done; otherwise err is 0.
//
// Timing: start sampled at edge k -> busy after k, done for the single cycle
// after edge k+DIGITS (busy already low then). Start is accepted again in
// the done cycle, giving one conversion per DIGITS+1 cycles.
// ----------------------------------------------------------------------------
module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  bcd_to_bin_if.slave  bus
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  // Horner step: acc*10 + digit, truncated to BIN_W bits.
  function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] acc,
                                             input logic [3:0]       dig);
    logic [BIN_W-1:0] t;
    t = (acc << 3) + (acc << 1) + BIN_W'(dig);
    return t;
  endfunction

  logic [0:0]          r_state;
  logic [4*DIGITS-1:0] r_shift;
  logic [BIN_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [BIN_W-1:0]    r_bin;

  logic [3:0]          w_top;
  logic [BIN_W-1:0]    w_acc_nxt;
  logic                w_last;

  assign w_top     = r_shift[4*DIGITS-1 -: 4];
  assign w_acc_nxt = mac10(r_acc, w_top);
  assign w_last    = (r_cnt == CNT_W'(DIGITS-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bin   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift <= bus.bcd_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        default: begin
          r_acc   <= w_acc_nxt;
          r_shift <= r_shift << 4;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // Final digit: publish result; busy drops on the same edge.
            r_bin   <= w_acc_nxt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic r_chk;
  logic r_err;
  logic w_bad;

  assign w_bad = (w_top > 4'd9);

  // Sticky invalid-digit flag, cleared at start, sampled into err at done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chk <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (bus.start) r_chk <= 1'b0;
      end else begin
        r_chk <= r_chk | w_bad;
        if (w_last) r_err <= r_chk | w_bad;
      end
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bin_out = r_bin;

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bcd_to_bin_if #(.DIGITS(2), .BIN_W(7))  b2();
  bcd_to_bin_if #(.DIGITS(3), .BIN_W(10)) b3();

  bcd_to_bin #(.DIGITS(2), .BIN_W(7))  u2 (.clk(clk), .reset_n(reset_n), .bus(b2));
  bcd_to_bin #(.DIGITS(3), .BIN_W(10)) u3 (.clk(clk), .reset_n(reset_n), .bus(b3));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] bcd;
    int         exp_bin;
    bit         exp_bad;
  } vec_t;

`ifdef BCD2BIN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: decimal positional value of the nibbles (literal for >9),
  // reduced modulo 2^w; err is set when any nibble exceeds 9.
  task automatic model(input logic [31:0] bcd, input int nd, input int w,
                       output longint v, output bit e);
    longint p;
    int nib;
    v = 0; e = 0; p = 1;
    for (int i = 0; i < nd; i++) begin
      nib = int'((bcd >> (4*i)) & 32'hF);
      v += longint'(nib) * p;
      p *= 10;
      if (nib > 9) e = 1;
    end
    v = v % (longint'(1) << w);
    e = e & CHK;
  endtask

  // Never busy and done together.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (b2.busy && b2.done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", b2.busy, b2.done);
      end
    end
  end

  task automatic conv2(input logic [7:0] bcd, input string tag,
                       output logic [6:0] bin, output logic e);
    int lat;
    @(negedge clk);
    b2.start = 1'b1; b2.bcd_in = bcd;
    @(posedge clk); #1;
    chk({tag, "_busy_after_start"}, b2.busy, 1);
    b2.start = 1'b0;
    b2.bcd_in = 8'($urandom);   // later changes must not matter
    lat = 0;
    while (!b2.done && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_busy_at_done"}, b2.busy, 0);
    bin = b2.bin_out; e = b2.err;
  endtask

  task automatic conv3(input logic [11:0] bcd, input string tag,
                       output logic [9:0] bin, output logic e);
    int lat;
    @(negedge clk);
    b3.start = 1'b1; b3.bcd_in = bcd;
    @(posedge clk); #1;
    b3.start = 1'b0;
    lat = 0;
    while (!b3.done && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    bin = b3.bin_out; e = b3.err;
  endtask

  initial begin
    vec_t vt[$];
    logic [6:0]  bin;
    logic [9:0]  bin3;
    logic        e;
    longint      mv;
    bit          me;
    int          n;

    vt.push_back('{8'h99, 99, 0});
    vt.push_back('{8'h00,  0, 0});
    vt.push_back('{8'h10, 10, 0});
    vt.push_back('{8'h09,  9, 0});
    vt.push_back('{8'h4A, 50, 1});
    vt.push_back('{8'h25, 25, 0});
    vt.push_back('{8'h87, 87, 0});
    vt.push_back('{8'hFF, 37, 1});   // 165 mod 128

    b2.start = 0; b2.bcd_in = '0;
    b3.start = 0; b3.bcd_in = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", b2.busy, 0);
    chk("rst_done", b2.done, 0);
    chk("rst_bin",  b2.bin_out, 0);
    chk("rst_err",  b2.err, 0);
    @(negedge clk); reset_n = 1'b1;

    // Table-driven vectors
    foreach (vt[i]) begin
      conv2(vt[i].bcd, $sformatf("vec%0d", i), bin, e);
      chk($sformatf("vec%0d_bin", i), bin, vt[i].exp_bin);
      chk($sformatf("vec%0d_err", i), e, vt[i].exp_bad & CHK);
    end

    // Start while busy is ignored
    @(negedge clk);
    b2.start = 1'b1; b2.bcd_in = 8'h25;
    @(posedge clk); #1;
    b2.bcd_in = 8'h77;              // start still high
    n = 0;
    while (!b2.done && n < 10) begin @(posedge clk); #1; n++; end
    chk("busy_ignore_bin", b2.bin_out, 25);
    b2.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("busy_ignore_idle", b2.busy, 0);
    end

    // Back-to-back with start held high
    @(negedge clk);
    b2.start = 1'b1; b2.bcd_in = 8'h25;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b2.done && n < 10);
    chk("b2b_first_bin", b2.bin_out, 25);
    b2.bcd_in = 8'h31;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b2.done && n < 10);
    chk("b2b_gap", n, 3);
    chk("b2b_second_bin", b2.bin_out, 31);
    b2.start = 1'b0;

    // Reset mid-conversion
    @(negedge clk);
    b2.start = 1'b1; b2.bcd_in = 8'h87;
    @(posedge clk); #1;
    b2.start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", b2.busy, 0);
    chk("mid_rst_done", b2.done, 0);
    chk("mid_rst_bin",  b2.bin_out, 0);
    chk("mid_rst_err",  b2.err, 0);
    #1 reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", b2.done, 0);
    end

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] r;
      r = (i % 4 == 0) ? 8'($urandom) : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      conv2(r, "rnd", bin, e);
      model(32'(r), 2, 7, mv, me);
      chk($sformatf("rnd_bin_%h", r), bin, mv);
      chk($sformatf("rnd_err_%h", r), e, me);
    end

    // Three-digit instance
    conv3(12'h999, "d3_999", bin3, e);
    chk("d3_999_bin", bin3, 999);
    chk("d3_999_err", e, 0);
    for (int i = 0; i < 10; i++) begin
      logic [11:0] r;
      r = (i % 3 == 0) ? 12'($urandom) :
          {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      conv3(r, "d3_rnd", bin3, e);
      model(32'(r), 3, 10, mv, me);
      chk($sformatf("d3_bin_%h", r), bin3, mv);
      chk($sformatf("d3_err_%h", r), e, me);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
